// File: rtl/mag_cmp_pkg.sv
// Shared types and sizing helpers for the sliced magnitude comparator.
package mag_cmp_pkg;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_res_t;

  localparam int SLICE_W = 4;

  function automatic int num_slices(input int n);
    return (n + SLICE_W - 1) / SLICE_W;
  endfunction

endpackage

// File: rtl/mag_comparator_slice.sv
// Combinational 4-bit compare slice; one leaf of the comparator tree.
module cmp_slice
  import mag_cmp_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output cmp_res_t           res
);

  always_comb begin
    res.gt = (a > b);
    res.lt = (a < b);
    res.eq = (a == b);
  end

endmodule

// File: rtl/mag_comparator.sv
// N-bit magnitude comparator: 4-bit slice tree, MSB-first combine, one register stage.
// Optional two's-complement mode is built in with `define CMP_SIGNED_EN (adds is_signed).
module mag_comparator
  import mag_cmp_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         in_valid,
`ifdef CMP_SIGNED_EN
  input  logic         is_signed,
`endif
  output logic         gt,
  output logic         lt,
  output logic         eq,
  output logic         out_valid
);

  localparam int NS = num_slices(N);
  localparam int PW = NS * SLICE_W;

  logic [PW-1:0] aPad, bPad;
  cmp_res_t      sliceRes [NS];
  cmp_res_t      treeRes;

  // Zero-padding the top slice keeps the padded bits equal, so they never decide.
  always_comb begin
    aPad        = '0;
    bPad        = '0;
    aPad[N-1:0] = A;
    bPad[N-1:0] = B;
`ifdef CMP_SIGNED_EN
    if (is_signed) begin
      aPad[N-1] = ~A[N-1];
      bPad[N-1] = ~B[N-1];
    end
`endif
  end

  for (genvar s = 0; s < NS; s++) begin : gSlice
    cmp_slice uSlice (
      .a   (aPad[s*SLICE_W +: SLICE_W]),
      .b   (bPad[s*SLICE_W +: SLICE_W]),
      .res (sliceRes[s])
    );
  end

  // Walking upward, any differing slice overrides what lies below it,
  // so the most-significant differing slice wins.
  always_comb begin
    logic allEq;
    treeRes = sliceRes[0];
    allEq   = sliceRes[0].eq;
    for (int i = 1; i < NS; i++) begin
      allEq = allEq & sliceRes[i].eq;
      if (!sliceRes[i].eq) begin
        treeRes.gt = sliceRes[i].gt;
        treeRes.lt = sliceRes[i].lt;
      end
    end
    treeRes.eq = allEq;
  end

  // Flags load only on valid, so idle-cycle operands (even X) never reach them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt        <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        gt <= treeRes.gt;
        lt <= treeRes.lt;
        eq <= treeRes.eq;
      end
    end
  end

endmodule

// File: tb/tb_mag_comparator.sv
// Self-checking bench: directed table on N=8, random compares on N=8 and N=64.
module tb_mag_comparator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  a8, b8;
  logic [63:0] a64, b64;
  logic        v8, v64;
  logic        isSigned;
  logic        gt8, lt8, eq8, ov8;
  logic        gt64, lt64, eq64, ov64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mag_comparator #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .in_valid(v8),
`ifdef CMP_SIGNED_EN
    .is_signed(isSigned),
`endif
    .gt(gt8), .lt(lt8), .eq(eq8), .out_valid(ov8)
  );

  mag_comparator #(.N(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .A(a64), .B(b64), .in_valid(v64),
`ifdef CMP_SIGNED_EN
    .is_signed(isSigned),
`endif
    .gt(gt64), .lt(lt64), .eq(eq64), .out_valid(ov64)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       v;
    logic [3:0] exp;  // {out_valid, gt, lt, eq}
    string      name;
  } vec_t;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual{ov,gt,lt,eq}=%b required=%b", name, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl[$];
    logic [3:0] exp8, exp64;

    tbl.push_back('{8'd4,  8'd4,  1'b1, 4'b1001, "eq_4_4"});
    tbl.push_back('{8'd32, 8'd32, 1'b1, 4'b1001, "eq_32_32"});
    tbl.push_back('{8'd4,  8'd2,  1'b1, 4'b1100, "gt_4_2"});
    tbl.push_back('{8'd64, 8'd32, 1'b1, 4'b1100, "gt_64_32"});
    tbl.push_back('{8'd32, 8'd8,  1'b1, 4'b1100, "gt_32_8"});
    tbl.push_back('{8'd2,  8'd4,  1'b1, 4'b1010, "lt_2_4"});
    tbl.push_back('{8'd32, 8'd64, 1'b1, 4'b1010, "lt_32_64"});
    tbl.push_back('{8'd8,  8'd32, 1'b1, 4'b1010, "lt_8_32"});
    tbl.push_back('{8'hFF, 8'h00, 1'b1, 4'b1100, "gt_ones_zero"});
    tbl.push_back('{8'h00, 8'hFF, 1'b1, 4'b1010, "lt_zero_ones"});
    tbl.push_back('{8'hFF, 8'hFF, 1'b1, 4'b1001, "eq_ones"});
    tbl.push_back('{8'h10, 8'h0F, 1'b1, 4'b1100, "gt_slice_boundary"});
    // back-to-back eq, gt, lt then an idle gap holding lt
    tbl.push_back('{8'd4,  8'd4,  1'b1, 4'b1001, "b2b_eq"});
    tbl.push_back('{8'd4,  8'd2,  1'b1, 4'b1100, "b2b_gt"});
    tbl.push_back('{8'd2,  8'd4,  1'b1, 4'b1010, "b2b_lt"});
    tbl.push_back('{8'd9,  8'd1,  1'b0, 4'b0010, "gap_hold_lt"});
    tbl.push_back('{8'd0,  8'd0,  1'b0, 4'b0010, "gap_hold_lt2"});

    rst_n = 1'b1; a8 = '0; b8 = '0; v8 = 1'b0;
    a64 = '0; b64 = '0; v64 = 1'b0; isSigned = 1'b0;

    // Async reset: observe cleared outputs before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async_8",  {ov8, gt8, lt8, eq8}, 4'b0000);
    chk("reset_async_64", {ov64, gt64, lt64, eq64}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      a8 = tbl[i].a; b8 = tbl[i].b; v8 = tbl[i].v;
      step();
      chk(tbl[i].name, {ov8, gt8, lt8, eq8}, tbl[i].exp);
    end

    // Idle operands carrying X must leave the held flags untouched.
    @(negedge clk);
    a8 = 'x; b8 = 'x; v8 = 1'b0;
    step();
    chk("x_idle_hold", {ov8, gt8, lt8, eq8}, 4'b0010);

    // Reset mid-compare: clears at once, pending compare never appears.
    @(negedge clk);
    a8 = 8'd4; b8 = 8'd2; v8 = 1'b1;
    step();
    chk("pre_reset_gt", {ov8, gt8, lt8, eq8}, 4'b1100);
    @(negedge clk);
    a8 = 8'd2; b8 = 8'd4; v8 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_midop_immediate", {ov8, gt8, lt8, eq8}, 4'b0000);
    step();
    chk("reset_held_over_edge", {ov8, gt8, lt8, eq8}, 4'b0000);
    @(negedge clk);
    v8 = 1'b0;
    rst_n = 1'b1;
    step();
    chk("reset_dropped_pending", {ov8, gt8, lt8, eq8}, 4'b0000);

`ifdef CMP_SIGNED_EN
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; v8 = 1'b1; isSigned = 1'b1;
    step();
    chk("signed_80_01", {ov8, gt8, lt8, eq8}, 4'b1010);
    @(negedge clk);
    isSigned = 1'b0;
    step();
    chk("unsigned_80_01", {ov8, gt8, lt8, eq8}, 4'b1100);
`endif

    // Random phase: model holds last valid result, recomputes with plain compares.
    exp8  = {1'b0, 3'b000};
    exp64 = 4'b0000;
    @(negedge clk);
    v8 = 1'b0;
    step();
    chk("rand_start_8", {ov8, gt8, lt8, eq8}, 4'b0000);
    for (int n = 0; n < 300; n++) begin
      logic [7:0]  ra8, rb8;
      logic [63:0] ra64, rb64;
      logic        rv8, rv64;
      ra8  = 8'($urandom);
      rb8  = ($urandom_range(0, 3) == 0) ? ra8 : 8'($urandom);
      ra64 = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rb64 = ra64;
        1: rb64 = ra64 ^ (64'd1 << $urandom_range(0, 63));
        default: rb64 = {$urandom, $urandom};
      endcase
      rv8  = ($urandom_range(0, 3) != 0);
      rv64 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      a8 = ra8; b8 = rb8; v8 = rv8;
      a64 = ra64; b64 = rb64; v64 = rv64;
      if (rv8) exp8 = {1'b1, ra8 > rb8, ra8 < rb8, ra8 == rb8};
      else     exp8[3] = 1'b0;
      if (rv64) exp64 = {1'b1, ra64 > rb64, ra64 < rb64, ra64 == rb64};
      else      exp64[3] = 1'b0;
      step();
      chk("rand_n8",  {ov8, gt8, lt8, eq8}, exp8);
      chk("rand_n64", {ov64, gt64, lt64, eq64}, exp64);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
